gpio_chirp_sync_gen: RTL and testbench
======================================

Name: gpio_chirp_sync_gen

Overview:
Transmit side of the GPIO chirp sync link. Generates the external square sync signal that the chirp sync receiver locks to. Each rising edge marks a chirp start, and the block emits a one-cycle TRIG strobe on that edge. The block sits in the CLOCK_IN domain, drives a GPIO pin, and supports continuous or fixed-length burst operation.

Parameters:
CNT_W, 32, width of the period, high-time and phase counters
BURST_W, 16, width of the burst length and chirp counter

Ports:
CLOCK_IN  input  1  system clock; all logic is on its rising edge
RST_N  input  1  asynchronous, active-low reset
EN  input  1  level; 1 = run, 0 = stop at the end of the current period
PERIOD  input  CNT_W  sync period in CLOCK_IN cycles
HIGH_TIME  input  CNT_W  high portion of each period in cycles
BURST  input  BURST_W  number of periods per run; 0 = continuous
SIG_OUT  output  1  registered square sync output to the GPIO
TRIG  output  1  one-cycle strobe, coincident with the SIG_OUT rising edge
BUSY  output  1  high while a run is in progress
CHIRP_CNT  output  BURST_W  periods started in the current run; wraps at 2^BURST_W
PHASE  output  CNT_W  cycle index within the current period, 0..P-1

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; SIG_OUT=0, TRIG=0, BUSY=0, CHIRP_CNT=0, PHASE=0; shadow registers cleared.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Shadow load: PERIOD, HIGH_TIME and BURST are captured into shadow registers at the start of every period. Input changes mid-period take effect at the next period boundary.
- Clamping, applied at load:
  - P = max(PERIOD, 2).
  - H = HIGH_TIME clamped to the range 1..P-1.
  - Result: every period has at least one high cycle and one low cycle.
- States: IDLE, HIGH, LOW.
- IDLE:
  - If EN=1 is sampled at edge n: load shadows, enter HIGH, CHIRP_CNT<=1, PHASE<=0.
  - At edge n: SIG_OUT<=1, TRIG<=1, BUSY<=1. Latency from EN to SIG_OUT is one cycle.
- HIGH:
  - PHASE increments by 1 each cycle.
  - When PHASE==H-1: next state LOW, SIG_OUT<=0.
- LOW:
  - PHASE increments by 1 each cycle.
  - When PHASE==P-1 (period end), evaluate in this priority order:
    - (a) EN=0 -> IDLE, BUSY<=0.
    - (b) burst done (BURST_shadow!=0 and periods completed==BURST_shadow) -> IDLE, BUSY<=0.
    - (c) otherwise -> HIGH: PHASE<=0, reload shadows, CHIRP_CNT+1, SIG_OUT<=1, TRIG<=1.
- TRIG is high for exactly one cycle per period start and is 0 at all other times.
- EN falling mid-period: the current period completes normally (graceful stop) and no truncated pulse is produced.
- EN re-asserted before the period end: no effect; the run continues.
- Burst complete with EN still 1: the block stays in IDLE. A new run needs EN low for at least one cycle and then high again (rising-edge re-arm).
- In continuous mode (BURST=0), EN held high runs indefinitely.
- CHIRP_CNT wraps at 2^BURST_W with no side effect. It resets to 1 at the start of each new run and holds its value while in IDLE.
- Counter arithmetic is unsigned modulo 2^CNT_W. A PERIOD of all ones is legal.
- Reset asserted mid-period: SIG_OUT drops immediately and asynchronously. After RST_N deasserts, the block starts from IDLE, and EN must be sampled high to start a run.

Test Plan:
- PERIOD=10, HIGH_TIME=3, BURST=0, EN held 1 -> SIG_OUT is 3 cycles high, 7 cycles low, repeating. TRIG pulses every 10 cycles, aligned to the SIG_OUT rising edge. CHIRP_CNT counts 1,2,3…
- PERIOD=8, HIGH_TIME=4, BURST=3, EN held 1 -> exactly 3 pulses, then BUSY=0 at cycle 24 after start. SIG_OUT stays 0 while EN stays 1. A low-high toggle on EN restarts the run with CHIRP_CNT=1.
- PERIOD=20, HIGH_TIME=5, EN dropped at PHASE=2 -> the full 20-cycle period still completes, then IDLE. TRIG fires once in total.
- Clamping:
  - PERIOD=1, HIGH_TIME=0 -> P=2, H=1: SIG_OUT toggles every cycle.
  - PERIOD=5, HIGH_TIME=9 -> H=4: 4 cycles high, 1 cycle low.
- PERIOD changed from 10 to 6 at PHASE=4 -> the current period stays at 10 cycles and the next period is 6 cycles.
- RST_N pulsed low at PHASE=1 of a HIGH phase -> SIG_OUT=0 and all outputs at reset values before the next clock edge. Restart needs EN to be sampled high.

Source files
------------

// File: rtl/gpio_chirp_sync_gen.sv
// Transmit side of the GPIO chirp sync link: square sync output with a TRIG
// strobe on each rising edge, running continuously or for a fixed burst.
module gpio_chirp_sync_gen #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               CLOCK_IN,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [CNT_W-1:0]   PERIOD,
  input  logic [CNT_W-1:0]   HIGH_TIME,
  input  logic [BURST_W-1:0] BURST,
  output logic               SIG_OUT,
  output logic               TRIG,
  output logic               BUSY,
  output logic [BURST_W-1:0] CHIRP_CNT,
  output logic [CNT_W-1:0]   PHASE
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0]   C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   C_TWO   = CNT_W'(2);
  localparam logic [BURST_W-1:0] C_B_ONE = BURST_W'(1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_period, r_high, r_phase;
  logic [BURST_W-1:0] r_burst, r_chirp_cnt;
  logic               r_sig, r_trig, r_busy, r_rearm;

  logic [CNT_W-1:0]   w_p, w_h, w_phase_nxt;
  logic [BURST_W-1:0] w_chirp_nxt;
  logic               w_sig_nxt, w_trig_nxt, w_busy_nxt, w_rearm_nxt;
  logic               w_start, w_high_end, w_period_end, w_burst_done;
  logic               w_restart, w_load;

  // Clamp so every period has at least one high and one low cycle.
  assign w_p = (PERIOD < C_TWO) ? C_TWO : PERIOD;
  assign w_h = (HIGH_TIME == '0) ? C_ONE :
               (HIGH_TIME >= w_p) ? (w_p - C_ONE) : HIGH_TIME;

  // A completed burst leaves r_rearm set until EN is seen low again.
  assign w_start      = (r_state == S_IDLE) && EN && !r_rearm;
  assign w_high_end   = (r_state == S_HIGH) && (r_phase == r_high - C_ONE);
  assign w_period_end = (r_state == S_LOW) && (r_phase == r_period - C_ONE);
  assign w_burst_done = (r_burst != '0) && (r_chirp_cnt == r_burst);
  assign w_restart    = w_period_end && EN && !w_burst_done;
  assign w_load       = w_start || w_restart;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLOCK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_sig       <= 1'b0;
      r_trig      <= 1'b0;
      r_busy      <= 1'b0;
      r_rearm     <= 1'b0;
      r_chirp_cnt <= '0;
      r_phase     <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_burst     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sig       <= w_sig_nxt;
      r_trig      <= w_trig_nxt;
      r_busy      <= w_busy_nxt;
      r_rearm     <= w_rearm_nxt;
      r_chirp_cnt <= w_chirp_nxt;
      r_phase     <= w_phase_nxt;
      if (w_load) begin
        r_period <= w_p;
        r_high   <= w_h;
        r_burst  <= BURST;
      end
    end
  end

  // NOTE: each combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_high_end) w_state_nxt = S_LOW;
      S_LOW:   if (w_period_end) w_state_nxt = w_restart ? S_HIGH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sig_nxt   = (w_state_nxt == S_HIGH);
    w_trig_nxt  = w_load;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_phase_nxt = r_phase + C_ONE;
    if (w_load || (w_state_nxt == S_IDLE))
      w_phase_nxt = '0;
    w_chirp_nxt = r_chirp_cnt;
    if (w_start)
      w_chirp_nxt = C_B_ONE;
    else if (w_restart)
      w_chirp_nxt = r_chirp_cnt + C_B_ONE;
    w_rearm_nxt = r_rearm;
    if (!EN)
      w_rearm_nxt = 1'b0;
    else if (w_period_end && w_burst_done)
      w_rearm_nxt = 1'b1;
  end

  assign SIG_OUT   = r_sig;
  assign TRIG      = r_trig;
  assign BUSY      = r_busy;
  assign CHIRP_CNT = r_chirp_cnt;
  assign PHASE     = r_phase;

endmodule

// File: tb/tb_gpio_chirp_sync_gen.sv
// Directed bench for gpio_chirp_sync_gen: expected per-cycle outputs are queued
// when stimulus is applied and compared one cycle at a time.
module tb_gpio_chirp_sync_gen;

  logic        CLOCK_IN;
  logic        RST_N;
  logic        EN;
  logic [31:0] PERIOD;
  logic [31:0] HIGH_TIME;
  logic [15:0] BURST;
  logic        SIG_OUT;
  logic        TRIG;
  logic        BUSY;
  logic [15:0] CHIRP_CNT;
  logic [31:0] PHASE;

  typedef struct packed {
    logic        sig;
    logic        trig;
    logic        busy;
    logic [15:0] chirp;
    logic        chk_phase;
    logic [31:0] phase;
  } exp_t;

  exp_t  sb_q[$];
  int    checks   = 0;
  int    failures = 0;
  string cur_tag  = "init";

  gpio_chirp_sync_gen #(.CNT_W(32), .BURST_W(16)) dut (
    .CLOCK_IN (CLOCK_IN),
    .RST_N    (RST_N),
    .EN       (EN),
    .PERIOD   (PERIOD),
    .HIGH_TIME(HIGH_TIME),
    .BURST    (BURST),
    .SIG_OUT  (SIG_OUT),
    .TRIG     (TRIG),
    .BUSY     (BUSY),
    .CHIRP_CNT(CHIRP_CNT),
    .PHASE    (PHASE)
  );

  initial CLOCK_IN = 1'b0;
  always #5 CLOCK_IN = ~CLOCK_IN;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_IN);
    #1;
  endtask

  // Queue phases lo..hi of a period with high time h.
  task automatic push_period(input int h, input int chirp, input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      e.sig       = (i < h);
      e.trig      = (i == 0);
      e.busy      = 1'b1;
      e.chirp     = 16'(chirp);
      e.chk_phase = 1'b1;
      e.phase     = 32'(i);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n, input int chirp, input logic chk_ph);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.sig       = 1'b0;
      e.trig      = 1'b0;
      e.busy      = 1'b0;
      e.chirp     = 16'(chirp);
      e.chk_phase = chk_ph;
      e.phase     = '0;
      sb_q.push_back(e);
    end
  endtask

  task automatic run_sb();
    exp_t e;
    int   cyc = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tick();
      check($sformatf("%s[%0d].sig", cur_tag, cyc), 32'(SIG_OUT), 32'(e.sig));
      check($sformatf("%s[%0d].trig", cur_tag, cyc), 32'(TRIG), 32'(e.trig));
      check($sformatf("%s[%0d].busy", cur_tag, cyc), 32'(BUSY), 32'(e.busy));
      check($sformatf("%s[%0d].chirp", cur_tag, cyc), 32'(CHIRP_CNT), 32'(e.chirp));
      if (e.chk_phase)
        check($sformatf("%s[%0d].phase", cur_tag, cyc), PHASE, e.phase);
      cyc++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".sig"}, 32'(SIG_OUT), 32'd0);
    check({tag, ".trig"}, 32'(TRIG), 32'd0);
    check({tag, ".busy"}, 32'(BUSY), 32'd0);
    check({tag, ".chirp"}, 32'(CHIRP_CNT), 32'd0);
    check({tag, ".phase"}, PHASE, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; PERIOD = '0; HIGH_TIME = '0; BURST = '0;
    tick(); tick();
    check_reset_outputs("reset");
    #3 RST_N = 1'b1;
    tick();

    // Continuous 10/3, three periods, EN dropped exactly at the period end.
    cur_tag = "cont"; PERIOD = 10; HIGH_TIME = 3; BURST = 0; EN = 1'b1;
    for (int k = 1; k <= 3; k++) push_period(3, k, 0, 9);
    run_sb();
    EN = 1'b0;
    push_idle(2, 3, 1'b0);
    run_sb();

    // Burst of 3 with EN held high, then the rising-edge re-arm.
    cur_tag = "burst"; PERIOD = 8; HIGH_TIME = 4; BURST = 3; EN = 1'b1;
    for (int k = 1; k <= 3; k++) push_period(4, k, 0, 7);
    push_idle(5, 3, 1'b0);
    run_sb();
    cur_tag = "rearm"; EN = 1'b0;
    push_idle(1, 3, 1'b0);
    run_sb();
    EN = 1'b1;
    push_period(4, 1, 0, 7);
    run_sb();
    EN = 1'b0;
    push_idle(2, 1, 1'b0);
    run_sb();

    // Graceful stop: EN dropped at PHASE=2 of a 20/5 period.
    cur_tag = "stop"; PERIOD = 20; HIGH_TIME = 5; BURST = 0; EN = 1'b1;
    push_period(5, 1, 0, 2);
    run_sb();
    EN = 1'b0;
    push_period(5, 1, 3, 19);
    push_idle(3, 1, 1'b0);
    run_sb();

    // EN dropped then re-asserted before the period end: run continues.
    cur_tag = "blip"; PERIOD = 6; HIGH_TIME = 2; EN = 1'b1;
    push_period(2, 1, 0, 1);
    run_sb();
    EN = 1'b0;
    push_period(2, 1, 2, 3);
    run_sb();
    EN = 1'b1;
    push_period(2, 1, 4, 5);
    push_period(2, 2, 0, 5);
    run_sb();
    EN = 1'b0;
    push_idle(2, 2, 1'b0);
    run_sb();

    // Clamp PERIOD=1, HIGH_TIME=0 -> P=2, H=1.
    cur_tag = "clamp_min"; PERIOD = 1; HIGH_TIME = 0; EN = 1'b1;
    for (int k = 1; k <= 3; k++) push_period(1, k, 0, 1);
    run_sb();
    EN = 1'b0;
    push_idle(2, 3, 1'b0);
    run_sb();

    // Clamp PERIOD=5, HIGH_TIME=9 -> H=4.
    cur_tag = "clamp_high"; PERIOD = 5; HIGH_TIME = 9; EN = 1'b1;
    for (int k = 1; k <= 2; k++) push_period(4, k, 0, 4);
    run_sb();
    EN = 1'b0;
    push_idle(2, 2, 1'b0);
    run_sb();

    // PERIOD changed mid-period takes effect at the next boundary.
    cur_tag = "shadow"; PERIOD = 10; HIGH_TIME = 3; EN = 1'b1;
    push_period(3, 1, 0, 4);
    run_sb();
    PERIOD = 6;
    push_period(3, 1, 5, 9);
    push_period(3, 2, 0, 5);
    run_sb();
    EN = 1'b0;
    push_idle(2, 2, 1'b0);
    run_sb();

    // Asynchronous reset at PHASE=1 of a HIGH phase.
    cur_tag = "mid_rst"; PERIOD = 10; HIGH_TIME = 3; EN = 1'b1;
    push_period(3, 1, 0, 1);
    run_sb();
    #2 RST_N = 1'b0; EN = 1'b0;
    #1 check_reset_outputs("async_rst");
    #2 RST_N = 1'b1;
    tick();
    cur_tag = "post_rst";
    push_idle(2, 0, 1'b1);
    run_sb();
    EN = 1'b1;
    push_period(3, 1, 0, 9);
    run_sb();
    EN = 1'b0;
    push_idle(2, 1, 1'b0);
    run_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
